// File: rtl/dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dadda_mul_arbiter (with helper dadda_16)
// Purpose  : Two requesters share one 16x16 unsigned Dadda multiplier.
//            A 3-state FSM (IDLE -> CALC -> DONE) grants one requester,
//            registers its operands, registers the product and holds the
//            result until the consumer takes it.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req0_valid/a/b, req0_ready - requester 0 handshake + operands
//            req1_valid/a/b, req1_ready - requester 1 handshake + operands
//            res_valid, res_id, res_product, res_ready - result handshake
// Config   : DADDA_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins
//            contention; otherwise round-robin via last_grant.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// dadda_16: combinational unsigned 16x16 -> 32 multiplier. Partial products
// are reduced column by column using the Dadda height sequence
// 13, 9, 6, 4, 3, 2; the remaining rows go through a final carry-propagate add.
// ----------------------------------------------------------------------------
module dadda_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] p
);
    localparam int NSTG = 6;
    localparam int DSEQ [NSTG] = '{13, 9, 6, 4, 3, 2};

    logic        col  [32][32];
    logic        nxt  [32][32];
    int          cnt  [32];
    int          ncnt [32];
    logic [31:0] w_row;
    int          idx;
    int          h;
    int          t;
    logic        x;
    logic        y;
    logic        z;

    always_comb begin
        w_row = '0;
        p     = '0;
        idx   = 0;
        h     = 0;
        t     = 0;
        x     = 1'b0;
        y     = 1'b0;
        z     = 1'b0;
        for (int c = 0; c < 32; c++) begin
            cnt[c]  = 0;
            ncnt[c] = 0;
            for (int r = 0; r < 32; r++) begin
                col[c][r] = 1'b0;
                nxt[c][r] = 1'b0;
            end
        end

        // Partial-product matrix, bits stacked per weight column
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                t = i + j;
                col[t[4:0]][cnt[t[4:0]]] = a[i] & b[j];
                cnt[t[4:0]] = cnt[t[4:0]] + 1;
            end
        end

        for (int s = 0; s < NSTG; s++) begin
            for (int c = 0; c < 32; c++) begin
                ncnt[c] = 0;
                for (int r = 0; r < 32; r++) begin
                    nxt[c][r] = 1'b0;
                end
            end
            for (int c = 0; c < 32; c++) begin
                // Carries already dropped into this column by column c-1
                // count toward its output height for this stage.
                idx = 0;
                h   = cnt[c] + ncnt[c];
                for (int k = 0; k < 8; k++) begin
                    if (h > DSEQ[s] && (idx + 1) < cnt[c]) begin
                        x = col[c][idx[4:0]];
                        y = col[c][t[4:0]];
                        t = idx + 1;
                        y = col[c][t[4:0]];
                        if ((h - DSEQ[s]) >= 2 && (idx + 2) < cnt[c]) begin
                            t = idx + 2;
                            z = col[c][t[4:0]];
                            nxt[c][ncnt[c][4:0]] = x ^ y ^ z;
                            ncnt[c] = ncnt[c] + 1;
                            if (c < 31) begin
                                nxt[c+1][ncnt[c+1][4:0]] = (x & y) | (x & z) | (y & z);
                                ncnt[c+1] = ncnt[c+1] + 1;
                            end
                            idx = idx + 3;
                            h   = h - 2;
                        end else begin
                            nxt[c][ncnt[c][4:0]] = x ^ y;
                            ncnt[c] = ncnt[c] + 1;
                            if (c < 31) begin
                                nxt[c+1][ncnt[c+1][4:0]] = x & y;
                                ncnt[c+1] = ncnt[c+1] + 1;
                            end
                            idx = idx + 2;
                            h   = h - 1;
                        end
                    end
                end
                // Untouched bits pass straight to the next stage
                for (int k = 0; k < 32; k++) begin
                    if (k >= idx && k < cnt[c]) begin
                        nxt[c][ncnt[c][4:0]] = col[c][k];
                        ncnt[c] = ncnt[c] + 1;
                    end
                end
            end
            for (int c = 0; c < 32; c++) begin
                cnt[c] = ncnt[c];
                for (int r = 0; r < 32; r++) begin
                    col[c][r] = nxt[c][r];
                end
            end
        end

        // Final carry-propagate addition of the surviving rows
        for (int r = 0; r < 32; r++) begin
            w_row = '0;
            for (int c = 0; c < 32; c++) begin
                if (r < cnt[c]) begin
                    w_row[c] = col[c][r];
                end
            end
            p = p + w_row;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// dadda_mul_arbiter: top level
// ----------------------------------------------------------------------------
module dadda_mul_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    output logic        res_id,
    output logic [31:0] res_product,
    input  logic        res_ready
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] op_a_q;
    logic [15:0] op_b_q;
    logic        last_grant;
    logic        w_idle;
    logic        w_gnt1;
    logic [31:0] w_prod;

    dadda_16 u_dadda (
        .a (op_a_q),
        .b (op_b_q),
        .p (w_prod)
    );

    // w_gnt1 set means requester 1 wins; otherwise requester 0 wins if valid.
    always_comb begin
        w_idle = (r_state == S_IDLE);
`ifdef DADDA_ARB_FIXED_PRIO_EN
        w_gnt1 = req1_valid & ~req0_valid;
`else
        // Under contention the requester that did not win last time goes
        w_gnt1 = req1_valid & (~req0_valid | ~last_grant);
`endif
        req0_ready = ~rst & w_idle & req0_valid & ~w_gnt1;
        req1_ready = ~rst & w_idle & w_gnt1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            last_grant  <= 1'b1;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            res_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0_valid | req1_valid) begin
                        op_a_q     <= w_gnt1 ? req1_a : req0_a;
                        op_b_q     <= w_gnt1 ? req1_b : req0_b;
                        res_id     <= w_gnt1;
                        last_grant <= w_gnt1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    res_product <= w_prod;
                    res_valid   <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dadda_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dadda_mul_arbiter
// Purpose  : Self-checking bench for dadda_mul_arbiter. A transaction-level
//            model predicts readies and results every cycle; directed tests
//            pin literal products, ids, latency and backpressure behaviour.
// Config   : DADDA_ARB_FIXED_PRIO_EN selects fixed-priority expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dadda_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_ready;
    logic        res_valid;
    logic        res_id;
    logic [31:0] res_product;
    logic        res_ready;

    int checks = 0;
    int fails  = 0;

    dadda_mul_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_ready  (req1_ready),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_product (res_product),
        .res_ready   (res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
        end
    endtask

    // Arbitration rule expressed on the request pattern and previous winner
    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef DADDA_ARB_FIXED_PRIO_EN
        return 0;
`else
        return last ? 0 : 1;
`endif
    endfunction

    // ---------------- transaction model ----------------
    bit          m_init  = 0;
    int          m_phase = 0;   // 0 waiting for request, 1 computing, 2 holding result
    logic        m_valid = 0;
    logic        m_id    = 0;
    logic        m_last  = 1;
    logic [31:0] m_prod  = 0;
    logic [31:0] m_pend  = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_init  = 1;
            m_phase = 0;
            m_valid = 0;
            m_id    = 0;
            m_last  = 1;
            m_prod  = 0;
        end else if (m_init) begin
            if (m_phase == 0) begin
                if (req0_valid || req1_valid) begin
                    int w;
                    w = pick(req0_valid, req1_valid, m_last);
                    m_id    = (w == 1);
                    m_last  = (w == 1);
                    m_pend  = (w == 1) ? ({16'd0, req1_a} * {16'd0, req1_b})
                                       : ({16'd0, req0_a} * {16'd0, req0_b});
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_prod  = m_pend;
                m_valid = 1;
                m_phase = 2;
            end else begin
                if (res_ready) begin
                    m_valid = 0;
                    m_phase = 0;
                end
            end
        end
    end

    logic [31:0] log_p  [$];
    logic        log_id [$];

    always @(negedge clk) begin
        if (m_init) begin
            int w;
            w = pick(req0_valid, req1_valid, m_last);
            check("ready0", {31'd0, req0_ready},
                  {31'd0, (!rst && m_phase == 0 && req0_valid && w == 0)});
            check("ready1", {31'd0, req1_ready},
                  {31'd0, (!rst && m_phase == 0 && req1_valid && w == 1)});
            check("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
            check("res_product", res_product, m_prod);
            if (m_valid) check("res_id", {31'd0, res_id}, {31'd0, m_id});
            if (res_valid && res_ready && !rst) begin
                log_p.push_back(res_product);
                log_id.push_back(res_id);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One request through the full handshake; returns cycles from accept to res_valid
    task automatic do_req(input int r, input logic [15:0] a, input logic [15:0] b, output int lat);
        int n;
        if (r == 1) begin req1_a = a; req1_b = b; req1_valid = 1; end
        else        begin req0_a = a; req0_b = b; req0_valid = 1; end
        n = 0;
        @(negedge clk);
        while (!((r == 1) ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 0;
        req1_valid = 0;
        lat = 1;
        @(negedge clk);
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("result_timeout", 32'd1, 32'd0);
        cyc(2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        rst = 1; res_ready = 1;
        req0_valid = 1; req0_a = 16'h0001; req0_b = 16'h0001;
        req1_valid = 0; req1_a = 0; req1_b = 0;

        // Reset: 2 cycles with a request pending
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_product", res_product, 32'h0000_0000);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        req0_valid = 0;
        cyc(2);

        // Single request from requester 0
        base = log_p.size();
        do_req(0, 16'h1234, 16'h5678, lat);
        check("single_latency", lat, 32'd2);
        check("single_count", log_p.size(), base + 1);
        if (log_p.size() > base) begin
            check("single_product", log_p[base], 32'h0626_0060);
            check("single_id", {31'd0, log_id[base]}, 32'd0);
        end

        // Zero operand from requester 1 (also leaves last_grant = 1)
        base = log_p.size();
        do_req(1, 16'h0000, 16'hABCD, lat);
        check("zero_count", log_p.size(), base + 1);
        if (log_p.size() > base) begin
            check("zero_product", log_p[base], 32'h0000_0000);
            check("zero_id", {31'd0, log_id[base]}, 32'd1);
        end

        // Contention: both valid continuously for 4 issue slots
        base = log_p.size();
        req0_a = 16'hFFFF; req0_b = 16'h0001;
        req1_a = 16'h8000; req1_b = 16'h8000;
        req0_valid = 1; req1_valid = 1;
        cyc(12);
        req0_valid = 0; req1_valid = 0;
        cyc(6);
        check("cont_count_ok", {31'd0, (log_p.size() >= base + 4)}, 32'd1);
        if (log_p.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) begin
`ifdef DADDA_ARB_FIXED_PRIO_EN
                check("cont_id", {31'd0, log_id[base+i]}, 32'd0);
                check("cont_product", log_p[base+i], 32'h0000_FFFF);
`else
                check("cont_id", {31'd0, log_id[base+i]}, i % 2);
                check("cont_product", log_p[base+i], (i % 2 == 1) ? 32'h4000_0000 : 32'h0000_FFFF);
`endif
            end
        end

        // Backpressure: result held for 5 cycles, requester 0 kept waiting
        res_ready = 0;
        req1_a = 16'hFFFF; req1_b = 16'hFFFF; req1_valid = 1;
        lat = 0;
        @(negedge clk);
        while (!req1_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("bp_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req1_valid = 0;
        req0_a = 16'h0003; req0_b = 16'h0003; req0_valid = 1;
        lat = 0;
        @(negedge clk);
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("bp_result_timeout", 32'd1, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, res_valid}, 32'd1);
            check("bp_product", res_product, 32'hFFFE_0001);
            check("bp_ready0", {31'd0, req0_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        res_ready = 1;
        req0_valid = 0;
        @(negedge clk);
        check("bp_still_valid", {31'd0, res_valid}, 32'd1);
        @(negedge clk);
        check("bp_released", {31'd0, res_valid}, 32'd0);
        cyc(2);

        // Reset while the transaction is in CALC
        base = log_p.size();
        req0_a = 16'h0008; req0_b = 16'h0004; req0_valid = 1;
        lat = 0;
        @(negedge clk);
        while (!req0_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("mid_accept_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        req0_valid = 0;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        check("mid_valid", {31'd0, res_valid}, 32'd0);
        check("mid_product", res_product, 32'h0000_0000);
        cyc(3);
        check("mid_no_result", log_p.size(), base);
        do_req(0, 16'h0008, 16'h0004, lat);
        check("mid_retry_count", log_p.size(), base + 1);
        if (log_p.size() > base) begin
            check("mid_retry_product", log_p[base], 32'h0000_0020);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
`default_nettype wire
